// File: rtl/uart_rx_responder_pkg.sv
// Shared definitions for the memory-mapped UART receiver: register offsets,
// STATUS/CTRL bit positions and receive FSM state encodings.
package uart_rx_responder_pkg;

    localparam logic [3:0] RXDATA_OFS = 4'h0;
    localparam logic [3:0] STATUS_OFS = 4'h4;
    localparam logic [3:0] CTRL_OFS   = 4'h8;

    localparam int ST_EMPTY_BIT      = 0;
    localparam int ST_FULL_BIT       = 1;
    localparam int ST_COUNT_LSB      = 2;
    localparam int ST_OVERRUN_BIT    = 6;
    localparam int ST_FRAME_ERR_BIT  = 7;
    localparam int ST_PARITY_ERR_BIT = 8;

    localparam int CTRL_RX_EN_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    // Word address (addr[31:2]) of a register at byte offset ofs from base.
    function automatic logic [29:0] word_of(input logic [31:0] base, input logic [3:0] ofs);
        return base[31:2] + 30'(ofs[3:2]);
    endfunction

endpackage

// File: rtl/uart_rx_responder_rx_fifo.sv
// Synchronous FIFO with push/pop/full/empty/count; head is read combinationally
// so the bus can return the oldest entry in the same cycle it is addressed.
module uart_rx_responder_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]      count_reg, count_next;
    logic             do_push, do_pop;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign count = count_reg;
    assign head  = mem[rd_ptr_reg];

    // A pop on empty is ignored; a push on full is accepted only if a pop frees a slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + (AW+1)'(1);
            2'b01:   count_next = count_reg - (AW+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

endmodule

// File: rtl/uart_rx_responder.sv
// Memory-mapped 8N1 UART receiver with an 8-entry FIFO and level interrupt.
// Define UART_RX_PARITY_EN to receive 8E1 frames with a sticky parity_err flag.
module uart_rx_responder
    import uart_rx_responder_pkg::*;
#(
    parameter int          BAUD_DIV   = 5208,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0020
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rxd,
    output logic        irqout
);

    localparam int                AW        = $clog2(FIFO_DEPTH);
    localparam int                CNT_W     = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [29:0]       RXDATA_W  = word_of(BASE_ADDR, RXDATA_OFS);
    localparam logic [29:0]       STATUS_W  = word_of(BASE_ADDR, STATUS_OFS);
    localparam logic [29:0]       CTRL_W    = word_of(BASE_ADDR, CTRL_OFS);

    logic             rxd_meta_reg, rxs_reg;
    rx_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       idx_reg, idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic             armed_reg, armed_next;
    logic             parity_bad_reg, parity_bad_next;
    logic             rx_push, frame_err_set, parity_err_set;

    logic [1:0]       ctrl_reg;
    logic             frame_err_reg, overrun_reg, parity_err_reg;

    logic             sel_rx, sel_st, sel_ctrl, st_wr, fifo_pop, overrun_set;
    logic [7:0]       fifo_head;
    logic             fifo_full, fifo_empty;
    logic [AW:0]      fifo_count;
    logic [31:0]      status_word;
    logic             unused_bits;

    assign unused_bits = ^{addr[1:0], wdata[31:9], wdata[5:2]};

    assign sel_rx   = (addr[31:2] == RXDATA_W);
    assign sel_st   = (addr[31:2] == STATUS_W);
    assign sel_ctrl = (addr[31:2] == CTRL_W);
    assign st_wr    = wr && sel_st;
    assign fifo_pop = rd && sel_rx;

    // The line idles high, so the synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_meta_reg <= 1'b1;
            rxs_reg      <= 1'b1;
        end else begin
            rxd_meta_reg <= uart_rxd;
            rxs_reg      <= rxd_meta_reg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= RX_IDLE;
            cnt_reg        <= '0;
            idx_reg        <= '0;
            shift_reg      <= '0;
            armed_reg      <= 1'b1;
            parity_bad_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            shift_reg      <= shift_next;
            armed_reg      <= armed_next;
            parity_bad_reg <= parity_bad_next;
        end
    end

    // armed drops after a framing error and re-arms once the line is seen high.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        idx_next        = idx_reg;
        shift_next      = shift_reg;
        armed_next      = armed_reg | rxs_reg;
        parity_bad_next = parity_bad_reg;
        rx_push         = 1'b0;
        frame_err_set   = 1'b0;
        parity_err_set  = 1'b0;
        case (state_reg)
            RX_IDLE: begin
                if (ctrl_reg[CTRL_RX_EN_BIT] && armed_reg && !rxs_reg) begin
                    state_next = RX_START;
                    cnt_next   = '0;
                end
            end
            RX_START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next = '0;
                    if (rxs_reg) begin
                        state_next = RX_IDLE;
                    end else begin
                        state_next = RX_DATA;
                        idx_next   = '0;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next            = '0;
                    shift_next[idx_reg] = rxs_reg;
                    idx_next            = idx_reg + 3'd1;
                    if (idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = RX_PARITY;
`else
                        state_next = RX_STOP;
`endif
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next        = '0;
                    parity_bad_next = (rxs_reg != ^shift_reg);
                    parity_err_set  = (rxs_reg != ^shift_reg);
                    state_next      = RX_STOP;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
`endif
            RX_STOP: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next        = '0;
                    state_next      = RX_IDLE;
                    parity_bad_next = 1'b0;
                    if (rxs_reg) begin
                        rx_push = !parity_bad_reg;
                    end else begin
                        frame_err_set = 1'b1;
                        armed_next    = 1'b0;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    uart_rx_responder_rx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_push),
        .push_data (shift_reg),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign overrun_set = rx_push && fifo_full && !(fifo_pop && !fifo_empty);

    // Flag sets take priority over a simultaneous write-one-to-clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_reg       <= 2'b01;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
            parity_err_reg <= 1'b0;
        end else begin
            if (wr && sel_ctrl) ctrl_reg <= wdata[1:0];

            if (frame_err_set)                         frame_err_reg <= 1'b1;
            else if (st_wr && wdata[ST_FRAME_ERR_BIT]) frame_err_reg <= 1'b0;

            if (overrun_set)                           overrun_reg <= 1'b1;
            else if (st_wr && wdata[ST_OVERRUN_BIT])   overrun_reg <= 1'b0;

            if (parity_err_set)                         parity_err_reg <= 1'b1;
            else if (st_wr && wdata[ST_PARITY_ERR_BIT]) parity_err_reg <= 1'b0;
        end
    end

    always_comb begin
        status_word                    = '0;
        status_word[ST_EMPTY_BIT]      = fifo_empty;
        status_word[ST_FULL_BIT]       = fifo_full;
        status_word[ST_COUNT_LSB +: 4] = 4'(fifo_count);
        status_word[ST_OVERRUN_BIT]    = overrun_reg;
        status_word[ST_FRAME_ERR_BIT]  = frame_err_reg;
        status_word[ST_PARITY_ERR_BIT] = parity_err_reg;
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (sel_rx)        rdata = {24'b0, fifo_empty ? 8'h00 : fifo_head};
            else if (sel_st)   rdata = status_word;
            else if (sel_ctrl) rdata = {30'b0, ctrl_reg};
        end
    end

    assign irqout = ctrl_reg[CTRL_IRQ_EN_BIT] & ~fifo_empty;

endmodule

// File: doc/uart_rx_responder.md
Name: uart_rx_responder

Overview:
- Memory-mapped UART receiver that responds to the CPU data bus (rd/wr/addr/wdata/rdata) as a bus slave.
- Deserialises 8N1 frames from the RX pin into an 8-entry FIFO. The CPU drains the FIFO by loads and controls the block by stores.
- Raises a level interrupt while data is pending.
- Sits beside DataMem under the address-bit-30 peripheral decode.

Parameters:
- BAUD_DIV, 5208: clock cycles per bit (50 MHz / 9600 baud); legal range >= 4.
- FIFO_DEPTH, 8: receive FIFO entries; power of two.
- BASE_ADDR, 32'h4000_0020: word address of register 0.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset
- rd  input  1  bus read strobe
- wr  input  1  bus write strobe
- addr  input  32  bus byte address
- wdata  input  32  bus write data
- rdata  output  32  bus read data (combinational)
- uart_rxd  input  1  serial input, idle high, asynchronous to clk
- irqout  output  1  interrupt request, level

Behaviour:
- Reset (reset=0, async): all state is cleared.
  - FIFO empty; rx FSM in IDLE; ctrl = 2'b01 (rx_en=1, irq_en=0); sticky flags = 0.
  - Outputs: rdata=0, irqout=0.
- Register map (addr[31:2] is compared against BASE_ADDR[31:2]):
  - +0 RXDATA (R): {24'b0, head byte}. A read with rd=1 pops one entry at the next posedge. Reading while empty returns 0 and does not pop.
  - +4 STATUS (R / W1C): {24'b0, frame_err, overrun, count[3:0], full, empty}. Writing 1 to bit 7 or bit 6 clears that flag.
  - +8 CTRL (R/W): bit0 rx_en, bit1 irq_en; other bits read 0.
  - Any other address: rdata=0, writes are ignored.
- rdata is combinational: it is 0 unless rd=1 and the address hits. This gives zero-latency reads for the single-cycle CPU.
- Input sync: uart_rxd passes through a 2-flop synchroniser, giving rxs.
- Receive FSM (a baud counter counts 0..BAUD_DIV-1; a bit index counts 0..7):
  - IDLE: if rx_en=1 and rxs=0, load counter and go to START.
  - START: after BAUD_DIV/2 cycles, resample. If rxs=0, go to DATA with index=0; if rxs=1, treat as a glitch and return to IDLE with no flag.
  - DATA: every BAUD_DIV cycles, sample rxs into shift[index], LSB first. After index 7, go to STOP.
  - STOP: after BAUD_DIV cycles, sample.
    - rxs=1: push the byte, then go to IDLE.
    - rxs=0: set frame_err, discard the byte, go to IDLE (a new start is only detected after rxs returns high).
- rx_en cleared mid-frame: the current frame completes; no new start is accepted afterwards.
- FIFO rules:
  - Push while full with no pop in the same cycle: drop the byte and set overrun; contents are unchanged.
  - Push and pop in the same cycle:
    - Not empty: both occur, count is unchanged; when full, the push is accepted with no overrun.
    - Empty: the pop is ignored and the push occurs; count becomes 1.
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. count is log2+1 bits, zero-extended into the 4-bit status field.
- Simultaneous events:
  - A W1C write in the same cycle that a flag sets: the set wins.
  - A CTRL write in the same cycle as a start edge: the new rx_en applies from the next cycle.
- irqout = irq_en & ~empty, registered-state derived with no pulse stretching.
- Latency: a byte is visible in RXDATA 1 cycle after the STOP sample, i.e. about 9.5 bit times after the start falling edge, plus 2 synchroniser cycles.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: the frame is 8E1. A PARITY state between DATA and STOP samples the even-parity bit.
  - On mismatch, set sticky parity_err (STATUS bit 8, W1C) and discard the byte at STOP.
  - Latency increases by one bit time.
- Undefined: 8N1 only; STATUS bit 8 reads 0 and there is no PARITY state.

Decomposition:
- Shared package/header holds:
  - register offsets (RXDATA_OFS=0, STATUS_OFS=4, CTRL_OFS=8);
  - STATUS bit positions;
  - FSM state encodings (IDLE, START, DATA, PARITY, STOP).
- One sub-module is natural: rx_fifo, a synchronous FIFO with push/pop/full/empty/count, parameterised by width and depth.

Test Plan:
- Reset, then send 8N1 byte 8'hA5 at BAUD_DIV=16 → STATUS reads 32'h0000_0004 (count=1, empty=0) and RXDATA reads 32'h0000_00A5. On the next cycle STATUS=32'h0000_0001.
- Send 9 bytes 8'h01..8'h09 without reading → full=1, overrun=1, count=8. Reads return 01..08, then 0. Writing 32'h40 to STATUS clears overrun.
- Force the stop bit to 0 on byte 8'h3C → frame_err=1, FIFO stays empty, irqout=0.
- Write CTRL=32'h3, send 8'h7E → irqout rises 1 cycle after the STOP sample and falls on the cycle after the RXDATA read.
- With FIFO full (8 entries), issue an RXDATA read in the exact push cycle → no overrun, count stays 8, and the oldest byte is returned.
- Apply a 3-cycle low glitch on uart_rxd, and separately assert reset mid-DATA → no byte is pushed; after reset, STATUS=32'h1 and CTRL=32'h1.
